// File: rtl/seg_scan_arbiter.sv
// Shares a multiplexed 4-digit 7-segment display between two requesters.
// Ownership changes only at frame ends; digits are scanned with a blanking gap.
module seg_scan_arbiter #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 32768,
   parameter int unsigned BLANK_CYCLES = 64,
   parameter int unsigned HOLD_FRAMES  = 16
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic [1:0]  i_req,
   input  logic [19:0] i_data0,
   input  logic [19:0] i_data1,
   output logic [1:0]  o_gnt,
   output logic        o_frame,
   output logic [3:0]  drains,
   output logic [7:0]  leds
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

   localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [1:0]    LAST_DIGIT = 2'(NUM_DIGITS - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN0 = 2'd1;
   localparam logic [1:0] S_OWN1 = 2'd2;

   logic [PW-1:0] r_presc;
   logic [1:0]    r_digit;
   logic [1:0]    r_state;
   logic          r_last;
   logic [HW-1:0] r_hold;
   logic [19:0]   r_buf;
   logic          r_frame;
   logic [3:0]    r_drains;
   logic [7:0]    r_leds;

   logic          w_tick;
   logic          w_frame_end;
   logic          w_blank;
   logic          w_expired;
   logic [1:0]    w_state_d;
   logic          w_last_d;
   logic [HW-1:0] w_hold_d;
   logic [4:0]    w_field;
   logic [6:0]    w_seg;

   assign w_tick      = (r_presc == PRESC_MAX);
   assign w_frame_end = w_tick && (r_digit == LAST_DIGIT);
   assign w_blank     = (r_presc < BLANK_END);
   assign w_expired   = (r_hold >= HOLD_MAX);

   // Arbitration decision; only committed on a frame end.
   always_comb begin
      w_state_d = r_state;
      w_last_d  = r_last;
      w_hold_d  = r_hold;
      case (r_state)
         S_IDLE: begin
            if (i_req == 2'b11) begin
               w_state_d = r_last ? S_OWN0 : S_OWN1;
            end else if (i_req[0]) begin
               w_state_d = S_OWN0;
            end else if (i_req[1]) begin
               w_state_d = S_OWN1;
            end
         end
         S_OWN0: begin
            if (!i_req[0]) begin
               w_state_d = i_req[1] ? S_OWN1 : S_IDLE;
            end else if (w_expired && i_req[1]) begin
               w_state_d = S_OWN1;
            end
         end
         S_OWN1: begin
            if (!i_req[1]) begin
               w_state_d = i_req[0] ? S_OWN0 : S_IDLE;
            end else if (w_expired && i_req[0]) begin
               w_state_d = S_OWN0;
            end
         end
         default: w_state_d = S_IDLE;
      endcase

      if ((w_state_d != r_state) && (w_state_d != S_IDLE)) begin
         w_last_d = (w_state_d == S_OWN1);
         w_hold_d = HOLD_ONE;
      end else if ((w_state_d != S_IDLE) && !w_expired) begin
         w_hold_d = r_hold + 1'b1;
      end
   end

   always_comb begin
      w_field = 5'd0;
      case (r_digit)
         2'd0:    w_field = r_buf[4:0];
         2'd1:    w_field = r_buf[9:5];
         2'd2:    w_field = r_buf[14:10];
         default: w_field = r_buf[19:15];
      endcase
   end

   // Segment order is {g,f,e,d,c,b,a}.
   always_comb begin
      w_seg = 7'h00;
      case (w_field[3:0])
         4'h0:    w_seg = 7'h3F;
         4'h1:    w_seg = 7'h06;
         4'h2:    w_seg = 7'h5B;
         4'h3:    w_seg = 7'h4F;
         4'h4:    w_seg = 7'h66;
         4'h5:    w_seg = 7'h6D;
         4'h6:    w_seg = 7'h7D;
         4'h7:    w_seg = 7'h07;
         4'h8:    w_seg = 7'h7F;
         4'h9:    w_seg = 7'h6F;
         4'hA:    w_seg = 7'h77;
         4'hB:    w_seg = 7'h7C;
         4'hC:    w_seg = 7'h39;
         4'hD:    w_seg = 7'h5E;
         4'hE:    w_seg = 7'h79;
         default: w_seg = 7'h71;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_presc  <= '0;
         r_digit  <= '0;
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_hold   <= '0;
         r_buf    <= '0;
         r_frame  <= 1'b0;
         r_drains <= '0;
         r_leds   <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_digit <= (r_digit == LAST_DIGIT) ? 2'd0 : r_digit + 1'b1;
         end
         r_frame <= w_frame_end;
         if (w_frame_end) begin
            r_state <= w_state_d;
            r_last  <= w_last_d;
            r_hold  <= w_hold_d;
            // In IDLE the buffer keeps the last owner's word on display.
            if (w_state_d == S_OWN0) begin
               r_buf <= i_data0;
            end else if (w_state_d == S_OWN1) begin
               r_buf <= i_data1;
            end
         end
         r_drains <= w_blank ? 4'b0000 : (4'b0001 << r_digit);
         r_leds   <= w_blank ? 8'h00 : {w_field[4], w_seg};
      end
   end

   assign o_gnt   = {r_state == S_OWN1, r_state == S_OWN0};
   assign o_frame = r_frame;
   assign drains  = r_drains;
   assign leds    = r_leds;

endmodule
